// File: rtl/pipe_ctrl_seq_if.sv
// rtl/pipe_ctrl_seq_if.sv - stall/flush control bundle between the pipeline stages and the sequencer
//
// Purpose: groups stage stall requests, exception inputs and the stall/flush
// control outputs of pipe_ctrl_seq into one bundle.
// Ports (signals):
//   stallreq_from_id/ex/mem  stage stall requests
//   excepttype_i             exception code from MEM, 0 = none
//   cp0_epc_i                current EPC, used by eret
//   stall[5:0]               stall bus: [0] pc .. [5] wb
//   flush                    pipeline flush
//   new_pc                   redirect target, valid while flush=1
//   stall_timeout            sticky stall watchdog flag
//   stall_cycles_total       total stall cycles, wraps
//   exc_count                exceptions taken, wraps
// Modports: master = sequencer side, slave = pipeline side.
interface pipe_ctrl_seq_if #(
    parameter int CNT_W = 32
);
    logic             stallreq_from_id;
    logic             stallreq_from_ex;
    logic             stallreq_from_mem;
    logic [31:0]      excepttype_i;
    logic [31:0]      cp0_epc_i;
    logic [5:0]       stall;
    logic             flush;
    logic [31:0]      new_pc;
    logic             stall_timeout;
    logic [CNT_W-1:0] stall_cycles_total;
    logic [15:0]      exc_count;

    modport master (
        input  stallreq_from_id,
        input  stallreq_from_ex,
        input  stallreq_from_mem,
        input  excepttype_i,
        input  cp0_epc_i,
        output stall,
        output flush,
        output new_pc,
        output stall_timeout,
        output stall_cycles_total,
        output exc_count
    );

    modport slave (
        output stallreq_from_id,
        output stallreq_from_ex,
        output stallreq_from_mem,
        output excepttype_i,
        output cp0_epc_i,
        input  stall,
        input  flush,
        input  new_pc,
        input  stall_timeout,
        input  stall_cycles_total,
        input  exc_count
    );
endinterface

// File: rtl/pipe_ctrl_seq.sv
// rtl/pipe_ctrl_seq.sv - pipeline stall/flush sequencer with exception redirect and stall statistics
//
// Purpose: arbitrates ID/EX/MEM stall requests and the exception path, drives
// the shared stall[5:0] and flush buses, holds the redirect PC for a
// programmable flush window, and keeps stall statistics plus a watchdog.
// Ports:
//   clk   clock, all state updates on posedge
//   rst   synchronous active-high reset
//   bus   pipe_ctrl_seq_if.master: stage requests/exception in, stall/flush/new_pc
//         and debug counters out
module pipe_ctrl_seq #(
    parameter int          FLUSH_CYCLES = 1,
    parameter int          MAX_STALL    = 1024,
    parameter int          CNT_W        = 32,
    parameter logic [31:0] INT_VECTOR   = 32'h0000_0020,
    parameter logic [31:0] EXC_VECTOR   = 32'h0000_0040
) (
    input  logic            clk,
    input  logic            rst,
    pipe_ctrl_seq_if.master bus
);

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } state_t;

    // Consecutive-stall counter only needs to reach MAX_STALL (it saturates).
    localparam int                CONS_W     = $clog2(MAX_STALL + 1);
    localparam logic [CONS_W-1:0] CONS_MAX   = CONS_W'(MAX_STALL);
    // The exception cycle itself is the first flush cycle, so FLUSH covers the rest.
    localparam logic [3:0]        FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

    localparam logic [5:0] MASK_MEM = 6'b011111;
    localparam logic [5:0] MASK_EX  = 6'b001111;
    localparam logic [5:0] MASK_ID  = 6'b000111;

    state_t            state_q;
    state_t            state_d;
    logic [3:0]        flush_cnt_q;
    logic [3:0]        flush_cnt_d;
    logic [31:0]       held_pc_q;
    logic [CONS_W-1:0] cons_q;
    logic [CONS_W-1:0] cons_d;
    logic              timeout_q;
    logic [CNT_W-1:0]  total_q;
    logic [15:0]       exc_cnt_q;

    logic              exc_hit;
    logic [31:0]       vec_pc;
    logic [5:0]        stall_d;
    logic              flush_d;
    logic [31:0]       new_pc_d;
    logic              take_exc;
    logic              stall_cycle;

    assign exc_hit = (bus.excepttype_i != 32'd0);

    // Redirect target decode; eret returns to EPC, interrupts to their own vector.
    always_comb begin
        vec_pc = EXC_VECTOR;
        case (bus.excepttype_i)
            32'h0000_0001: vec_pc = INT_VECTOR;
            32'h0000_000e: vec_pc = bus.cp0_epc_i;
            default:       vec_pc = EXC_VECTOR;
        endcase
    end

    // Next state and all bus outputs. Outputs are forced low during reset
    // even though IDLE decode is purely combinational from the inputs.
    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        stall_d     = 6'b000000;
        flush_d     = 1'b0;
        new_pc_d    = 32'd0;
        take_exc    = 1'b0;
        if (!rst) begin
            case (state_q)
                IDLE: begin
                    if (exc_hit) begin
                        flush_d  = 1'b1;
                        new_pc_d = vec_pc;
                        take_exc = 1'b1;
                        if (FLUSH_CYCLES > 1) begin
                            state_d     = FLUSH;
                            flush_cnt_d = FLUSH_LOAD;
                        end
                    end else if (bus.stallreq_from_mem) begin
                        stall_d = MASK_MEM;
                    end else if (bus.stallreq_from_ex) begin
                        stall_d = MASK_EX;
                    end else if (bus.stallreq_from_id) begin
                        stall_d = MASK_ID;
                    end
                end
                FLUSH: begin
                    // Requests and new exceptions are ignored; the flush kills their source.
                    flush_d     = 1'b1;
                    new_pc_d    = held_pc_q;
                    flush_cnt_d = flush_cnt_q - 4'd1;
                    if (flush_cnt_q == 4'd1) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign stall_cycle = (stall_d != 6'b000000);

    // Any non-stall cycle (idle, exception, flush) breaks the consecutive run.
    always_comb begin
        cons_d = '0;
        if (stall_cycle) begin
            cons_d = (cons_q == CONS_MAX) ? cons_q : cons_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            flush_cnt_q <= 4'd0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            held_pc_q <= 32'd0;
            exc_cnt_q <= 16'd0;
        end else if (take_exc) begin
            held_pc_q <= vec_pc;
            exc_cnt_q <= exc_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cons_q    <= '0;
            timeout_q <= 1'b0;
            total_q   <= '0;
        end else begin
            cons_q <= cons_d;
            if (stall_cycle) begin
                total_q <= total_q + 1'b1;
                if (cons_d == CONS_MAX) begin
                    timeout_q <= 1'b1;
                end
            end
        end
    end

    assign bus.stall              = stall_d;
    assign bus.flush              = flush_d;
    assign bus.new_pc             = new_pc_d;
    assign bus.stall_timeout      = timeout_q;
    assign bus.stall_cycles_total = total_q;
    assign bus.exc_count          = exc_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl_seq.sv
// tb/tb_pipe_ctrl_seq.sv - bench for pipe_ctrl_seq with three flush-length variants
module tb_pipe_ctrl_seq;

    localparam int MAXS = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        id;
    logic        ex;
    logic        mem;
    logic [31:0] exc;
    logic [31:0] epc;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pipe_ctrl_seq_if #(.CNT_W(32)) if0 ();
    pipe_ctrl_seq_if #(.CNT_W(32)) if1 ();
    pipe_ctrl_seq_if #(.CNT_W(32)) if2 ();

    assign if0.stallreq_from_id = id;  assign if1.stallreq_from_id = id;  assign if2.stallreq_from_id = id;
    assign if0.stallreq_from_ex = ex;  assign if1.stallreq_from_ex = ex;  assign if2.stallreq_from_ex = ex;
    assign if0.stallreq_from_mem = mem; assign if1.stallreq_from_mem = mem; assign if2.stallreq_from_mem = mem;
    assign if0.excepttype_i = exc;     assign if1.excepttype_i = exc;     assign if2.excepttype_i = exc;
    assign if0.cp0_epc_i = epc;        assign if1.cp0_epc_i = epc;        assign if2.cp0_epc_i = epc;

    pipe_ctrl_seq #(.FLUSH_CYCLES(1), .MAX_STALL(MAXS), .CNT_W(32)) dut0 (.clk(clk), .rst(rst), .bus(if0));
    pipe_ctrl_seq #(.FLUSH_CYCLES(3), .MAX_STALL(MAXS), .CNT_W(32)) dut1 (.clk(clk), .rst(rst), .bus(if1));
    pipe_ctrl_seq #(.FLUSH_CYCLES(4), .MAX_STALL(MAXS), .CNT_W(32)) dut2 (.clk(clk), .rst(rst), .bus(if2));

    logic [5:0]  a_stall [3];
    logic        a_flush [3];
    logic [31:0] a_pc    [3];
    logic        a_to    [3];
    logic [31:0] a_tot   [3];
    logic [15:0] a_exc   [3];

    assign a_stall[0] = if0.stall;  assign a_stall[1] = if1.stall;  assign a_stall[2] = if2.stall;
    assign a_flush[0] = if0.flush;  assign a_flush[1] = if1.flush;  assign a_flush[2] = if2.flush;
    assign a_pc[0] = if0.new_pc;    assign a_pc[1] = if1.new_pc;    assign a_pc[2] = if2.new_pc;
    assign a_to[0] = if0.stall_timeout; assign a_to[1] = if1.stall_timeout; assign a_to[2] = if2.stall_timeout;
    assign a_tot[0] = if0.stall_cycles_total; assign a_tot[1] = if1.stall_cycles_total; assign a_tot[2] = if2.stall_cycles_total;
    assign a_exc[0] = if0.exc_count; assign a_exc[1] = if1.exc_count; assign a_exc[2] = if2.exc_count;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: remaining flush cycles after the current one, held PC, counters.
    int          m_fleft [3];
    logic [31:0] m_pc    [3];
    logic [31:0] m_tot   [3];
    int          m_cons  [3];
    logic        m_to    [3];
    logic [15:0] m_exc   [3];
    bit          started = 1'b0;

    function automatic int fc_of(input int k);
        return (k == 0) ? 1 : (k == 1) ? 3 : 4;
    endfunction

    function automatic logic [31:0] vec_of(input logic [31:0] c, input logic [31:0] e);
        if (c == 32'h1) return 32'h20;
        if (c == 32'he) return e;
        return 32'h40;
    endfunction

    function automatic logic [5:0] req_mask(input logic r_id, input logic r_ex, input logic r_mem);
        if (r_mem) return 6'b011111;
        if (r_ex)  return 6'b001111;
        if (r_id)  return 6'b000111;
        return 6'b000000;
    endfunction

    function automatic bool_flush_t(input int k);
        return 0;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            started = 1'b1;
            for (int k = 0; k < 3; k++) begin
                m_fleft[k] = 0; m_pc[k] = 0; m_tot[k] = 0;
                m_cons[k] = 0;  m_to[k] = 0; m_exc[k] = 0;
            end
        end else begin
            for (int k = 0; k < 3; k++) begin
                if (m_fleft[k] > 0) begin
                    m_fleft[k] = m_fleft[k] - 1;
                    m_cons[k]  = 0;
                end else if (exc != 0) begin
                    m_pc[k]    = vec_of(exc, epc);
                    m_exc[k]   = m_exc[k] + 16'd1;
                    m_fleft[k] = fc_of(k) - 1;
                    m_cons[k]  = 0;
                end else if (req_mask(id, ex, mem) != 0) begin
                    m_tot[k] = m_tot[k] + 32'd1;
                    if (m_cons[k] < MAXS) m_cons[k] = m_cons[k] + 1;
                    if (m_cons[k] == MAXS) m_to[k] = 1'b1;
                end else begin
                    m_cons[k] = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            for (int k = 0; k < 3; k++) begin
                logic        e_flush;
                logic [31:0] e_pc;
                logic [5:0]  e_stall;
                e_flush = 1'b0; e_pc = 32'd0; e_stall = 6'd0;
                if (!rst) begin
                    if (m_fleft[k] > 0) begin
                        e_flush = 1'b1; e_pc = m_pc[k];
                    end else if (exc != 0) begin
                        e_flush = 1'b1; e_pc = vec_of(exc, epc);
                    end else begin
                        e_stall = req_mask(id, ex, mem);
                    end
                end
                chk($sformatf("d%0d_stall", k), 64'(a_stall[k]), 64'(e_stall));
                chk($sformatf("d%0d_flush", k), 64'(a_flush[k]), 64'(e_flush));
                chk($sformatf("d%0d_new_pc", k), 64'(a_pc[k]), 64'(e_pc));
                chk($sformatf("d%0d_timeout", k), 64'(a_to[k]), 64'(m_to[k]));
                chk($sformatf("d%0d_total", k), 64'(a_tot[k]), 64'(m_tot[k]));
                chk($sformatf("d%0d_exc_count", k), 64'(a_exc[k]), 64'(m_exc[k]));
            end
        end
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; id = 1'b0; ex = 1'b0; mem = 1'b0; exc = 32'd0; epc = 32'd0;
        nxt();
        ex = 1'b1;
        @(negedge clk);
        chk("rst_stall", 64'(a_stall[0]), 64'd0);
        chk("rst_exc_count", 64'(a_exc[0]), 64'd0);
        chk("rst_total", 64'(a_tot[0]), 64'd0);
        nxt();
        ex = 1'b0; rst = 1'b0;

        // T1: EX stall for three cycles
        ex = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("t1_stall", 64'(a_stall[0]), 64'h0f);
            chk("t1_flush", 64'(a_flush[0]), 64'd0);
            nxt();
        end
        ex = 1'b0;
        @(negedge clk);
        chk("t1_idle", 64'(a_stall[0]), 64'd0);
        chk("t1_total", 64'(a_tot[0]), 64'd3);
        nxt();

        // T2: interrupt beats a MEM stall in the same cycle
        exc = 32'h1; mem = 1'b1;
        @(negedge clk);
        chk("t2_flush", 64'(a_flush[0]), 64'd1);
        chk("t2_stall", 64'(a_stall[0]), 64'd0);
        chk("t2_pc", 64'(a_pc[0]), 64'h20);
        nxt();
        exc = 32'h0;
        @(negedge clk);
        chk("t2_stall_after", 64'(a_stall[0]), 64'h1f);
        chk("t2_flush_after", 64'(a_flush[0]), 64'd0);
        chk("t2_exc_count", 64'(a_exc[0]), 64'd1);
        nxt();
        mem = 1'b0;
        repeat (4) nxt();

        // T3: eret with 3-cycle flush, second exception dropped
        exc = 32'he; epc = 32'h0000_1234;
        @(negedge clk);
        chk("t3_flush0", 64'(a_flush[1]), 64'd1);
        chk("t3_pc0", 64'(a_pc[1]), 64'h1234);
        nxt();
        exc = 32'h8;
        @(negedge clk);
        chk("t3_flush1", 64'(a_flush[1]), 64'd1);
        chk("t3_pc1", 64'(a_pc[1]), 64'h1234);
        nxt();
        exc = 32'h0;
        @(negedge clk);
        chk("t3_flush2", 64'(a_flush[1]), 64'd1);
        chk("t3_pc2", 64'(a_pc[1]), 64'h1234);
        nxt();
        @(negedge clk);
        chk("t3_flush_end", 64'(a_flush[1]), 64'd0);
        chk("t3_exc_count", 64'(a_exc[1]), 64'd2);
        repeat (2) nxt();

        // T5: 3 stalls, 1 idle, 3 stalls stays under the watchdog
        id = 1'b1; repeat (3) nxt();
        id = 1'b0; nxt();
        id = 1'b1; repeat (3) nxt();
        id = 1'b0;
        @(negedge clk);
        chk("t5_timeout", 64'(a_to[0]), 64'd0);
        chk("t5_total", 64'(a_tot[0]), 64'd10);
        chk("t5_total_d1", 64'(a_tot[1]), 64'd9);
        nxt();

        // T4: four consecutive stalls trip the watchdog, which is sticky
        id = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("t4_timeout_low", 64'(a_to[0]), 64'd0);
            nxt();
        end
        id = 1'b0;
        @(negedge clk);
        chk("t4_timeout_high", 64'(a_to[0]), 64'd1);
        chk("t4_stall_clear", 64'(a_stall[0]), 64'd0);
        nxt();
        exc = 32'h5;
        nxt();
        exc = 32'h0;
        @(negedge clk);
        chk("t4_timeout_sticky", 64'(a_to[0]), 64'd1);
        repeat (4) nxt();

        // T6: reset on the second cycle of a 4-cycle flush
        exc = 32'hc;
        @(negedge clk);
        chk("t6_flush0", 64'(a_flush[2]), 64'd1);
        chk("t6_pc0", 64'(a_pc[2]), 64'h40);
        nxt();
        exc = 32'h0; rst = 1'b1;
        @(negedge clk);
        chk("t6_rst_flush", 64'(a_flush[2]), 64'd0);
        chk("t6_rst_pc", 64'(a_pc[2]), 64'd0);
        nxt();
        rst = 1'b0; ex = 1'b1;
        @(negedge clk);
        chk("t6_stall", 64'(a_stall[2]), 64'h0f);
        chk("t6_flush", 64'(a_flush[2]), 64'd0);
        chk("t6_exc_count", 64'(a_exc[2]), 64'd0);
        chk("t6_timeout_cleared", 64'(a_to[0]), 64'd0);
        nxt();
        ex = 1'b0;
        repeat (2) nxt();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl_seq.md
Name: pipe_ctrl_seq

Overview:
- Pipeline control sequencer for the five-stage core.
- Arbitrates stall requests from the ID, EX and MEM stages and from the exception path, and drives the shared stall[5:0] and flush buses consumed by every pipeline register, including mem_wb.
- On an exception it computes and holds the redirect PC and keeps flush asserted for a programmable number of cycles.
- Keeps stall statistics and a stall watchdog for debug.

Parameters:
- FLUSH_CYCLES, 1: cycles flush stays asserted per exception; legal range 1..15.
- MAX_STALL, 1024: consecutive stall cycles that set stall_timeout; must be ≥1.
- CNT_W, 32: width of the stall_cycles_total counter.
- INT_VECTOR, 32'h00000020: redirect PC for interrupts.
- EXC_VECTOR, 32'h00000040: redirect PC for all other exceptions.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset; synchronous, active-high.
- stallreq_from_id  in  1  ID-stage stall request.
- stallreq_from_ex  in  1  EX-stage stall request (multi-cycle mul/div).
- stallreq_from_mem  in  1  MEM-stage stall request (bus wait).
- excepttype_i  in  32  exception code from MEM; 0 = none.
- cp0_epc_i  in  32  current EPC, used by eret.
- stall  out  6  stall bus: [0] pc, [1] if, [2] id, [3] ex, [4] mem, [5] wb; 1 = stop.
- flush  out  1  pipeline flush to all pipeline registers and the pc register.
- new_pc  out  32  redirect target; valid while flush=1.
- stall_timeout  out  1  sticky watchdog flag.
- stall_cycles_total  out  CNT_W  total stall cycles, wraps.
- exc_count  out  16  exceptions taken, wraps.

Behaviour:

Reset:
- While rst=1: stall=0, flush=0, new_pc=0 (outputs forced even though decode is combinational).
- On the first clock edge with rst=1: stall_timeout=0, stall_cycles_total=0, exc_count=0, internal consecutive-stall counter=0, flush counter=0, FSM→IDLE.
- Reset mid-flush aborts the flush immediately.

FSM states: IDLE and FLUSH.

IDLE:
- stall, flush and new_pc are combinational from the current-cycle inputs, with zero latency.
- Priority, highest first:
  - excepttype_i≠0: flush=1, stall=6'b000000.
  - stallreq_from_mem: stall=6'b011111.
  - stallreq_from_ex: stall=6'b001111.
  - stallreq_from_id: stall=6'b000111.
  - otherwise: stall=0, flush=0.
- new_pc decode for excepttype_i:
  - 32'h1 → INT_VECTOR.
  - 32'he (eret) → cp0_epc_i.
  - 32'h8, 32'ha, 32'hc, 32'hd → EXC_VECTOR.
  - any other nonzero code → EXC_VECTOR.
  - no exception: new_pc=0.
- Exception taken in IDLE:
  - Latch new_pc into the held-PC register.
  - Increment exc_count; eret counts too.
  - If FLUSH_CYCLES>1: load flush counter with FLUSH_CYCLES-1 and go to FLUSH.
  - Otherwise stay in IDLE.

FLUSH:
- flush=1, stall=0, new_pc = held-PC register.
- All stall requests and excepttype_i are ignored; exc_count is not incremented.
- The flush counter decrements each cycle; at the edge where it reaches 0 the FSM returns to IDLE.
- Total flush-high time = exactly FLUSH_CYCLES consecutive cycles.

Stall accounting:
- A cycle is a stall cycle when stall≠0; FLUSH cycles and exception cycles are never stall cycles.
- stall_cycles_total increments on each stall cycle, modulo 2^CNT_W.
- Consecutive counter:
  - increments on a stall cycle, saturating at MAX_STALL;
  - clears to 0 on any non-stall cycle, including an exception cycle.
- stall_timeout:
  - set on the edge where the consecutive counter reaches MAX_STALL;
  - remains 1 until rst;
  - does not alter stall.

Simultaneous events:
- Exception and any stall request in the same IDLE cycle: the exception wins. stall=0, flush=1, and the consecutive counter clears.
- Several stall requests at once: the highest priority mask is driven; the masks are supersets, so stall is the OR result.
- An exception arriving during FLUSH is dropped; upstream flush kills its source.

Test Plan:
1. Reset; hold stallreq_from_ex=1 for 3 cycles, then 0 → stall=6'b001111 for 3 cycles then 0; stall_cycles_total=3; flush=0 throughout.
2. FLUSH_CYCLES=1; excepttype_i=32'h1 for one cycle with stallreq_from_mem=1 → that cycle flush=1, stall=0, new_pc=32'h20; next cycle stall=6'b011111; exc_count=1.
3. FLUSH_CYCLES=3; excepttype_i=32'he, cp0_epc_i=32'h0000_1234 for one cycle, then excepttype_i=32'h8 on the next cycle → flush=1 for exactly 3 cycles with new_pc=32'h1234 on all three; exc_count=1; the second exception is ignored.
4. MAX_STALL=4; stallreq_from_id=1 for 4 cycles → stall_timeout rises after the 4th stall cycle and stays 1 after the request drops and through later exceptions; it clears only on rst.
5. Stall 3 cycles, 1 idle cycle, stall 3 cycles with MAX_STALL=4 → stall_timeout remains 0; stall_cycles_total=6.
6. Enter FLUSH (FLUSH_CYCLES=4); assert rst on the 2nd flush cycle → same cycle flush=0; after the edge FSM=IDLE, exc_count=0, and subsequent requests are decoded normally.
